mvm_acc: RTL and testbench
==========================

# mvm_acc

Downstream stage of the 4-lane stochastic matrix-vector multiplier. It watches the multiplier's busy flag and captures the four 4-bit signed lane results at the end of every multiply pass. It accumulates them over a fixed number of passes (one pass per weight/input pair of a dot product) and presents the sums plus 4-bit saturated activations through a valid/ready handshake to the next layer.

## Interface
Parameters:
- K_PASSES, default 4: passes summed per output group; legal range 1..255.
- ACC_W, default 8: accumulator width per lane, signed two's complement; minimum 5.

Ports:
- i_clk_acc  in  1  clock; all state updates on rising edge.
- i_rst_acc  in  1  reset; asynchronous, active-high.
- i_clear_acc  in  1  synchronous start-of-group: clears accumulators, pass counter and overrun flag; enters COLLECT.
- i_ismvm  in  1  multiplier busy flag; a 1→0 transition marks a finished pass.
- i_wx_result  in  4 lanes x 4  lane results, each signed 4-bit (-8..7).
- i_ready  in  1  consumer accepts the output group.
- o_valid  out  1  output group available.
- o_acc  out  4 lanes x ACC_W  accumulated lane sums, signed.
- o_act  out  4 lanes x 4  lane sums clamped to -8..7.
- o_busy  out  1  high in COLLECT.
- o_overrun  out  1  sticky: a pass ended while a group was held.

## Operation
- Edge detect: ismvm_q is a registered copy of i_ismvm. done = ismvm_q & ~i_ismvm, evaluated combinationally. i_wx_result is sampled in the done cycle.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE: done is ignored. i_clear_acc → COLLECT.
  - COLLECT: on done, each lane acc += sign-extended lane result and pass_cnt += 1. When pass_cnt reaches K_PASSES on that done → HOLD.
  - HOLD: o_valid=1; o_acc and o_act are frozen. On o_valid & i_ready: acc=0 and pass_cnt=0 → COLLECT.
- Arithmetic:
  - Each lane is a signed saturating add. The result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and never wraps.
  - o_act = acc clamped to [-8, 7], computed from registered acc.
- Boundary conditions:
  - i_clear_acc with done in the same cycle: clear wins and the sample is discarded.
  - i_clear_acc in HOLD: o_valid drops next cycle and the group is discarded → COLLECT.
  - done in HOLD without a handshake in the same cycle: the sample is dropped, o_overrun is set, and acc is unchanged.
  - done in HOLD in the same cycle as the handshake: acc is loaded with the sample (not added), pass_cnt=1 → COLLECT. If K_PASSES=1, the state instead goes straight back to HOLD with the new value.
  - Reset at any time returns to IDLE with all state zero. In-progress sums are lost.
  - i_ismvm high out of reset: ismvm_q resets to 0, so no spurious done is generated.

## Timing
- Reset values:
  - o_valid=0, o_busy=0, o_overrun=0.
  - o_acc=0 and o_act=0 on all lanes.
  - State IDLE, pass_cnt=0, ismvm_q=0.
- done is asserted in the first cycle i_ismvm is 0 after being 1. The sample is registered at the end of that cycle.
- o_valid rises 1 cycle after the K_PASSES-th done cycle.
- o_valid stays high until the edge where i_ready=1, and falls the following cycle. i_ready may be held high continuously.
- o_acc and o_act change only in COLLECT updates or on clear/reset. They are stable throughout HOLD.
- o_busy is high exactly while in COLLECT.
- Throughput: one done per cycle is absorbed; back-to-back 1→0 transitions can be at most every 2 cycles by construction.

## Test plan
- Reset: assert i_rst_acc mid-cycle with i_ismvm=1 → all outputs are 0 immediately. Release, then drop i_ismvm → no accumulation (IDLE).
- Basic group (K_PASSES=4): clear, then 4 passes with lanes {1,2,-1,3} → o_valid 1 cycle after the 4th done, o_acc={4,8,-4,12}, o_act={4,7,-4,7}. With i_ready=1, o_valid is high for exactly 1 cycle.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid and issue an extra pass with {7,7,7,7} → o_overrun=1, o_acc unchanged. A later i_ready=1 completes the transfer. o_overrun stays 1 until i_clear_acc.
- Saturation (K_PASSES=20, ACC_W=6): 20 passes of {-8,7,0,-1} → o_acc={-32,31,0,-20}, o_act={-8,7,0,-8}.
- Simultaneous events:
  - i_clear_acc coincident with done after 2 passes of {1,1,1,1} → o_acc={0,0,0,0} and pass_cnt restarts at 0.
  - done coincident with handshake → new group starts with acc=sample and pass_cnt=1.
- Reset mid-COLLECT after 2 passes → IDLE, o_busy=0. A subsequent clear plus 4 passes yields only those 4 passes' sum.

Source files
------------

// File: rtl/mvm_acc.sv
// mvm_acc: accumulates the four signed lane results of the stochastic MVM
// over K_PASSES multiply passes and hands each group downstream on valid/ready.
// Ports:
//   i_clk_acc, i_rst_acc (async, active-high), i_clear_acc (start-of-group)
//   i_ismvm (multiplier busy), i_wx_result (4 x s4 lane results), i_ready
//   o_valid, o_acc (4 x sACC_W sums), o_act (4 x s4 clamped), o_busy, o_overrun
module mvm_acc #(
    parameter int K_PASSES = 4,
    parameter int ACC_W    = 8
) (
    input  logic               i_clk_acc,
    input  logic               i_rst_acc,
    input  logic               i_clear_acc,
    input  logic               i_ismvm,
    input  logic [15:0]        i_wx_result,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [4*ACC_W-1:0] o_acc,
    output logic [15:0]        o_act,
    output logic               o_busy,
    output logic               o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(K_PASSES - 1);
    localparam logic signed [ACC_W-1:0] LP_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LP_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] LP_ACT_MAX = ACC_W'(7);
    localparam logic signed [ACC_W-1:0] LP_ACT_MIN = ACC_W'(-8);

    state_t             r_state;
    state_t             w_next;
    logic               r_ismvm_q;
    logic [7:0]         r_pass_cnt;
    logic [ACC_W-1:0]   r_acc [4];
    logic               r_overrun;

    logic               w_done;
    logic               w_clr;
    logic               w_add;
    logic               w_load;
    logic               w_ovr_set;
    logic [ACC_W:0]     w_sum [4];
    logic [ACC_W-1:0]   w_sat [4];
    logic [ACC_W-1:0]   w_sext [4];

    // Falling edge of the busy flag marks the end of a multiply pass.
    assign w_done = r_ismvm_q & ~i_ismvm;

    // Sum in ACC_W+1 bits; differing top two bits mean the add overflowed.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_sext[l] = {{(ACC_W-4){i_wx_result[4*l+3]}}, i_wx_result[4*l +: 4]};
            w_sum[l]  = {r_acc[l][ACC_W-1], r_acc[l]}
                      + {{(ACC_W-3){i_wx_result[4*l+3]}}, i_wx_result[4*l +: 4]};
            if (w_sum[l][ACC_W] != w_sum[l][ACC_W-1])
                w_sat[l] = w_sum[l][ACC_W] ? LP_MIN : LP_MAX;
            else
                w_sat[l] = w_sum[l][ACC_W-1:0];
        end
    end

    always_ff @(posedge i_clk_acc or posedge i_rst_acc) begin
        if (i_rst_acc)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_add     = 1'b0;
        w_load    = 1'b0;
        w_ovr_set = 1'b0;
        if (i_clear_acc) begin
            // Clear dominates any coincident done or handshake.
            w_clr  = 1'b1;
            w_next = S_COLLECT;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next = S_IDLE;
                end
                S_COLLECT: begin
                    if (w_done) begin
                        w_add = 1'b1;
                        if (r_pass_cnt == LP_LAST)
                            w_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        if (w_done) begin
                            // Sample becomes first pass of the next group.
                            w_load = 1'b1;
                            w_next = (K_PASSES == 1) ? S_HOLD : S_COLLECT;
                        end else begin
                            w_clr  = 1'b1;
                            w_next = S_COLLECT;
                        end
                    end else if (w_done) begin
                        w_ovr_set = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_acc or posedge i_rst_acc) begin
        if (i_rst_acc) begin
            r_ismvm_q  <= 1'b0;
            r_pass_cnt <= 8'd0;
            r_overrun  <= 1'b0;
            for (int l = 0; l < 4; l++)
                r_acc[l] <= '0;
        end else begin
            r_ismvm_q <= i_ismvm;
            if (i_clear_acc)
                r_overrun <= 1'b0;
            else if (w_ovr_set)
                r_overrun <= 1'b1;
            if (w_clr)
                r_pass_cnt <= 8'd0;
            else if (w_load)
                r_pass_cnt <= 8'd1;
            else if (w_add)
                r_pass_cnt <= r_pass_cnt + 8'd1;
            for (int l = 0; l < 4; l++) begin
                if (w_clr)
                    r_acc[l] <= '0;
                else if (w_load)
                    r_acc[l] <= w_sext[l];
                else if (w_add)
                    r_acc[l] <= w_sat[l];
            end
        end
    end

    always_comb begin
        o_acc = '0;
        o_act = '0;
        for (int l = 0; l < 4; l++) begin
            o_acc[l*ACC_W +: ACC_W] = r_acc[l];
            if ($signed(r_acc[l]) > LP_ACT_MAX)
                o_act[4*l +: 4] = 4'b0111;
            else if ($signed(r_acc[l]) < LP_ACT_MIN)
                o_act[4*l +: 4] = 4'b1000;
            else
                o_act[4*l +: 4] = r_acc[l][3:0];
        end
    end

    assign o_valid   = (r_state == S_HOLD);
    assign o_busy    = (r_state == S_COLLECT);
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_mvm_acc.sv
// tb_mvm_acc: three mvm_acc configurations on shared stimulus, each
// compared every cycle against a behavioural model of the group rules.
module tb_mvm_acc;

    logic        clk = 1'b0;
    logic        rst, clear, ismvm, ready;
    logic [15:0] wx;

    logic        v0, b0, o0, v1, b1, o1, v2, b2, o2;
    logic [31:0] acc0;
    logic [23:0] acc1;
    logic [19:0] acc2;
    logic [15:0] act0, act1, act2;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mvm_acc #(.K_PASSES(4), .ACC_W(8)) u0 (
        .i_clk_acc(clk), .i_rst_acc(rst), .i_clear_acc(clear),
        .i_ismvm(ismvm), .i_wx_result(wx), .i_ready(ready),
        .o_valid(v0), .o_acc(acc0), .o_act(act0),
        .o_busy(b0), .o_overrun(o0));

    mvm_acc #(.K_PASSES(20), .ACC_W(6)) u1 (
        .i_clk_acc(clk), .i_rst_acc(rst), .i_clear_acc(clear),
        .i_ismvm(ismvm), .i_wx_result(wx), .i_ready(ready),
        .o_valid(v1), .o_acc(acc1), .o_act(act1),
        .o_busy(b1), .o_overrun(o1));

    mvm_acc #(.K_PASSES(1), .ACC_W(5)) u2 (
        .i_clk_acc(clk), .i_rst_acc(rst), .i_clear_acc(clear),
        .i_ismvm(ismvm), .i_wx_result(wx), .i_ready(ready),
        .o_valid(v2), .o_acc(acc2), .o_act(act2),
        .o_busy(b2), .o_overrun(o2));

    task automatic chk(string tag, int got, int exp);
        n_tot++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int kp(int d);
        return (d == 0) ? 4 : (d == 1) ? 20 : 1;
    endfunction

    function automatic int aw(int d);
        return (d == 0) ? 8 : (d == 1) ? 6 : 5;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int lanev(logic [15:0] x, int l);
        logic signed [3:0] t;
        t = x[l*4 +: 4];
        return t;
    endfunction

    function automatic logic [15:0] pk(int a, int b, int c, int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    function automatic int dacc(int d, int l);
        logic signed [7:0] s8;
        logic signed [5:0] s6;
        logic signed [4:0] s5;
        s8 = acc0[l*8 +: 8];
        s6 = acc1[l*6 +: 6];
        s5 = acc2[l*5 +: 5];
        return (d == 0) ? int'(s8) : (d == 1) ? int'(s6) : int'(s5);
    endfunction

    function automatic int dact(int d, int l);
        logic signed [3:0] t;
        t = (d == 0) ? act0[l*4 +: 4] : (d == 1) ? act1[l*4 +: 4] : act2[l*4 +: 4];
        return t;
    endfunction

    function automatic int dval(int d);
        return (d == 0) ? int'(v0) : (d == 1) ? int'(v1) : int'(v2);
    endfunction

    function automatic int dbusy(int d);
        return (d == 0) ? int'(b0) : (d == 1) ? int'(b1) : int'(b2);
    endfunction

    function automatic int dovr(int d);
        return (d == 0) ? int'(o0) : (d == 1) ? int'(o1) : int'(o2);
    endfunction

    // Behavioural model: mode 0 idle, 1 gathering passes, 2 group held.
    int m_acc [3][4];
    int m_cnt [3];
    int m_mode [3];
    bit m_ovr [3];
    bit m_prev;
    bit m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 1'b0;
            for (int d = 0; d < 3; d++) begin
                m_cnt[d] = 0; m_mode[d] = 0; m_ovr[d] = 1'b0;
                for (int l = 0; l < 4; l++) m_acc[d][l] = 0;
            end
        end else begin
            m_done = m_prev && !ismvm;
            m_prev = ismvm;
            for (int d = 0; d < 3; d++) begin
                int lim;
                lim = 1 << (aw(d) - 1);
                if (clear) begin
                    m_cnt[d] = 0; m_mode[d] = 1; m_ovr[d] = 1'b0;
                    for (int l = 0; l < 4; l++) m_acc[d][l] = 0;
                end else if (m_mode[d] == 1 && m_done) begin
                    for (int l = 0; l < 4; l++)
                        m_acc[d][l] = clampi(m_acc[d][l] + lanev(wx, l), -lim, lim - 1);
                    m_cnt[d]++;
                    if (m_cnt[d] == kp(d)) m_mode[d] = 2;
                end else if (m_mode[d] == 2 && ready) begin
                    for (int l = 0; l < 4; l++)
                        m_acc[d][l] = m_done ? lanev(wx, l) : 0;
                    m_cnt[d] = m_done ? 1 : 0;
                    m_mode[d] = (m_cnt[d] == kp(d)) ? 2 : 1;
                end else if (m_mode[d] == 2 && m_done) begin
                    m_ovr[d] = 1'b1;
                end
            end
        end
    end

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d.valid", d), dval(d), int'(m_mode[d] == 2));
            chk($sformatf("u%0d.busy", d), dbusy(d), int'(m_mode[d] == 1));
            chk($sformatf("u%0d.overrun", d), dovr(d), int'(m_ovr[d]));
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("u%0d.acc%0d", d, l), dacc(d, l), m_acc[d][l]);
                chk($sformatf("u%0d.act%0d", d, l), dact(d, l), clampi(m_acc[d][l], -8, 7));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic pass(logic [15:0] w);
        ismvm = 1'b1;
        tick();
        ismvm = 1'b0;
        wx = w;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic rst_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.u%0d.valid", d), dval(d), 0);
            chk($sformatf("rst.u%0d.busy", d), dbusy(d), 0);
            chk($sformatf("rst.u%0d.overrun", d), dovr(d), 0);
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("rst.u%0d.acc%0d", d, l), dacc(d, l), 0);
                chk($sformatf("rst.u%0d.act%0d", d, l), dact(d, l), 0);
            end
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; ismvm = 1'b1; ready = 1'b0; wx = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ismvm = 1'b0;
        wx = pk(3, 3, 3, 3);
        repeat (2) tick();
        chk("idle.busy", int'(b0), 0);
        chk("idle.acc0", dacc(0, 0), 0);

        // basic group, consumer always ready
        ready = 1'b1;
        do_clear();
        repeat (4) pass(pk(1, 2, -1, 3));
        chk("basic.valid", int'(v0), 1);
        chk("basic.acc0", dacc(0, 0), 4);
        chk("basic.acc1", dacc(0, 1), 8);
        chk("basic.acc2", dacc(0, 2), -4);
        chk("basic.acc3", dacc(0, 3), 12);
        chk("basic.act1", dact(0, 1), 7);
        chk("basic.act2", dact(0, 2), -4);
        chk("basic.act3", dact(0, 3), 7);
        tick();
        chk("basic.valid_drop", int'(v0), 0);

        // backpressure and overrun
        ready = 1'b0;
        do_clear();
        repeat (4) pass(pk(1, 2, -1, 3));
        repeat (3) tick();
        pass(pk(7, 7, 7, 7));
        repeat (5) tick();
        chk("bp.valid", int'(v0), 1);
        chk("bp.overrun", int'(o0), 1);
        chk("bp.acc0", dacc(0, 0), 4);
        chk("bp.acc3", dacc(0, 3), 12);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp.valid_drop", int'(v0), 0);
        chk("bp.overrun_sticky", int'(o0), 1);
        do_clear();
        chk("bp.overrun_clr", int'(o0), 0);

        // saturation on the K=20, 6-bit instance
        do_clear();
        repeat (20) pass(pk(-8, 7, 0, -1));
        chk("sat.valid", int'(v1), 1);
        chk("sat.acc0", dacc(1, 0), -32);
        chk("sat.acc1", dacc(1, 1), 31);
        chk("sat.acc2", dacc(1, 2), 0);
        chk("sat.acc3", dacc(1, 3), -20);
        chk("sat.act0", dact(1, 0), -8);
        chk("sat.act3", dact(1, 3), -8);

        // clear coincident with done
        ready = 1'b1;
        do_clear();
        repeat (2) pass(pk(1, 1, 1, 1));
        ismvm = 1'b1;
        tick();
        ismvm = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrdone.acc0", dacc(0, 0), 0);
        chk("clrdone.busy", int'(b0), 1);
        repeat (3) pass(pk(1, 1, 1, 1));
        chk("clrdone.valid3", int'(v0), 0);
        pass(pk(1, 1, 1, 1));
        chk("clrdone.valid4", int'(v0), 1);

        // done coincident with handshake
        ready = 1'b0;
        do_clear();
        repeat (4) pass(pk(1, 2, -1, 3));
        ismvm = 1'b1;
        tick();
        ismvm = 1'b0;
        wx = pk(2, 2, 2, 2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("hsdone.acc0", dacc(0, 0), 2);
        chk("hsdone.busy", int'(b0), 1);
        chk("hsdone.valid", int'(v0), 0);
        repeat (3) pass(pk(1, 1, 1, 1));
        chk("hsdone.valid_after3", int'(v0), 1);
        chk("hsdone.acc1", dacc(0, 1), 5);

        // reset mid-collect with ismvm high
        do_clear();
        repeat (2) pass(pk(2, 2, 2, 2));
        ismvm = 1'b1;
        rst_pulse();
        tick();
        ismvm = 1'b0;
        repeat (2) tick();
        chk("rstc.busy", int'(b0), 0);
        do_clear();
        repeat (4) pass(pk(1, 1, 1, 1));
        chk("rstc.acc0", dacc(0, 0), 4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ready = 1'($urandom_range(0, 1));
            if (r < 3) begin
                do_clear();
            end else if (r < 4) begin
                rst_pulse();
            end else if (r < 85) begin
                ismvm = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
                ismvm = 1'b0;
                wx = 16'($urandom);
                clear = ($urandom_range(0, 19) == 0);
                ready = 1'($urandom_range(0, 1));
                tick();
                clear = 1'b0;
                repeat ($urandom_range(0, 1)) tick();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
